sample_mem_arbiter: RTL and testbench

// - Shares the single read port of the wave sample memory between NUM_OSC oscillator playback readers and the

---
 rtl/sample_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_sample_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_mem_arbiter.sv
// Shares the single sample-BRAM read port between NUM_OSC oscillator readers and one debug reader.
// Round-robin among oscillators, with a forced debug slot once debug has waited DBG_MAX_WAIT cycles.
module sample_mem_arbiter #(
   parameter int NUM_OSC      = 4,
   parameter int ADDR_WIDTH   = 18,
   parameter int SAMPLE_WIDTH = 16,
   parameter int MEM_LATENCY  = 2,
   parameter int DBG_MAX_WAIT = 16
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic [NUM_OSC-1:0]              osc_req_in,
   input  logic [NUM_OSC*ADDR_WIDTH-1:0]   osc_addr_in,
   output logic [NUM_OSC-1:0]              osc_gnt_out,
   output logic [NUM_OSC-1:0]              osc_valid_out,
   output logic [NUM_OSC*SAMPLE_WIDTH-1:0] osc_data_out,
   input  logic                            dbg_req_in,
   input  logic [ADDR_WIDTH-1:0]           dbg_addr_in,
   output logic                            dbg_gnt_out,
   output logic                            dbg_valid_out,
   output logic [SAMPLE_WIDTH-1:0]         dbg_data_out,
   output logic [ADDR_WIDTH-1:0]           mem_addr_out,
   input  logic [SAMPLE_WIDTH-1:0]         mem_data_in
);

   localparam int SRC_W = $clog2(NUM_OSC + 1);
   localparam int PTR_W = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
   localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);
   localparam logic [SRC_W-1:0] DBG_ID = SRC_W'(NUM_OSC);

   logic [PTR_W-1:0]      rr_ptr;
   logic [CNT_W-1:0]      dbg_wait_cnt;
   logic                  osc_hit;
   logic [PTR_W-1:0]      osc_sel;
   logic                  dbg_force;
   logic                  gnt_osc;
   logic                  gnt_dbg;
   logic [SRC_W-1:0]      gnt_src;
   logic [ADDR_WIDTH-1:0] gnt_addr;

   logic                  tag_vld_p [MEM_LATENCY+1];
   logic [SRC_W-1:0]      tag_src_p [MEM_LATENCY+1];
   logic                  ret_vld;
   logic [SRC_W-1:0]      ret_src;

   // Round-robin search starting at rr_ptr
   always_comb begin
      osc_hit = 1'b0;
      osc_sel = '0;
      for (int i = 0; i < NUM_OSC; i++) begin
         int idx;
         idx = (int'(rr_ptr) + i) % NUM_OSC;
         if (!osc_hit && osc_req_in[idx]) begin
            osc_hit = 1'b1;
            osc_sel = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      dbg_force   = dbg_req_in && (dbg_wait_cnt == CNT_W'(DBG_MAX_WAIT));
      gnt_osc     = rst_n_in && osc_hit && !dbg_force;
      gnt_dbg     = rst_n_in && dbg_req_in && (dbg_force || !osc_hit);
      gnt_src     = gnt_dbg ? DBG_ID : SRC_W'(osc_sel);
      gnt_addr    = gnt_dbg ? dbg_addr_in : osc_addr_in[osc_sel*ADDR_WIDTH +: ADDR_WIDTH];
      osc_gnt_out = '0;
      if (gnt_osc) begin
         osc_gnt_out[osc_sel] = 1'b1;
      end
      dbg_gnt_out = gnt_dbg;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr       <= '0;
         dbg_wait_cnt <= '0;
      end else begin
         if (gnt_osc) begin
            rr_ptr <= (osc_sel == PTR_W'(NUM_OSC - 1)) ? '0 : osc_sel + 1'b1;
         end
         if (!dbg_req_in || gnt_dbg) begin
            dbg_wait_cnt <= '0;
         end else if (dbg_wait_cnt != CNT_W'(DBG_MAX_WAIT)) begin
            dbg_wait_cnt <= dbg_wait_cnt + 1'b1;
         end
      end
   end

   // Issue stage: address to BRAM, tag follows the read through the memory latency
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_addr_out <= '0;
         for (int i = 0; i <= MEM_LATENCY; i++) begin
            tag_vld_p[i] <= 1'b0;
            tag_src_p[i] <= '0;
         end
      end else begin
         if (gnt_osc || gnt_dbg) begin
            mem_addr_out <= gnt_addr;
         end
         tag_vld_p[0] <= gnt_osc || gnt_dbg;
         tag_src_p[0] <= gnt_src;
         for (int i = 1; i <= MEM_LATENCY; i++) begin
            tag_vld_p[i] <= tag_vld_p[i-1];
            tag_src_p[i] <= tag_src_p[i-1];
         end
      end
   end

   assign ret_vld = tag_vld_p[MEM_LATENCY];
   assign ret_src = tag_src_p[MEM_LATENCY];

   // Return stage: steer BRAM data to the source that issued the read
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         osc_valid_out <= '0;
         osc_data_out  <= '0;
         dbg_valid_out <= 1'b0;
         dbg_data_out  <= '0;
      end else begin
         osc_valid_out <= '0;
         dbg_valid_out <= 1'b0;
         if (ret_vld) begin
            if (ret_src == DBG_ID) begin
               dbg_valid_out <= 1'b1;
               dbg_data_out  <= mem_data_in;
            end else begin
               for (int k = 0; k < NUM_OSC; k++) begin
                  if (ret_src == SRC_W'(k)) begin
                     osc_valid_out[k]                             <= 1'b1;
                     osc_data_out[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= mem_data_in;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Bench for sample_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model (arbitration rules, return queue keyed by cycle, BRAM model).
module tb_sample_mem_arbiter;

   localparam int N   = 4;
   localparam int AW  = 18;
   localparam int SW  = 16;
   localparam int LAT = 2;
   localparam int DMW = 16;

   logic            clk_in = 1'b0;
   logic            rst_n_in = 1'b0;
   logic [N-1:0]    osc_req_in = '0;
   logic [N*AW-1:0] osc_addr_in = '0;
   logic [N-1:0]    osc_gnt_out;
   logic [N-1:0]    osc_valid_out;
   logic [N*SW-1:0] osc_data_out;
   logic            dbg_req_in = 1'b0;
   logic [AW-1:0]   dbg_addr_in = '0;
   logic            dbg_gnt_out;
   logic            dbg_valid_out;
   logic [SW-1:0]   dbg_data_out;
   logic [AW-1:0]   mem_addr_out;
   logic [SW-1:0]   mem_data_in;

   always #5 clk_in = ~clk_in;

   sample_mem_arbiter #(
      .NUM_OSC(N), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .MEM_LATENCY(LAT), .DBG_MAX_WAIT(DMW)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .osc_req_in(osc_req_in), .osc_addr_in(osc_addr_in), .osc_gnt_out(osc_gnt_out),
      .osc_valid_out(osc_valid_out), .osc_data_out(osc_data_out),
      .dbg_req_in(dbg_req_in), .dbg_addr_in(dbg_addr_in), .dbg_gnt_out(dbg_gnt_out),
      .dbg_valid_out(dbg_valid_out), .dbg_data_out(dbg_data_out),
      .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in)
   );

   // BRAM model: LAT-cycle read latency, data = addr[15:0] ^ A5A5
   logic [SW-1:0] mpipe [LAT];
   always @(posedge clk_in) begin
      mpipe[0] <= mem_addr_out[15:0] ^ 16'hA5A5;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mem_data_in = mpipe[LAT-1];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int            m_rr;
   int            m_cnt;
   logic [AW-1:0] m_addr;
   logic [SW-1:0] m_osc [N];
   logic [SW-1:0] m_dbg;
   int            ret_src [int];
   logic [SW-1:0] ret_dat [int];
   logic [N-1:0]  last_osc_gnt = '0;
   logic          last_dbg_gnt = 1'b0;

   function automatic logic [SW-1:0] memf(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   task automatic set_addr(input int k, input logic [AW-1:0] a);
      osc_addr_in[k*AW +: AW] = a;
   endtask

   task automatic model_clear();
      m_rr = 0;
      m_cnt = 0;
      m_addr = '0;
      for (int k = 0; k < N; k++) m_osc[k] = '0;
      m_dbg = '0;
      ret_src.delete();
      ret_dat.delete();
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      osc_req_in = '0;
      dbg_req_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      model_clear();
      rst_n_in = 1'b1;
   endtask

   // One clock of scoreboard checking; inputs are set by the caller before this is called
   task automatic cycle();
      logic [N-1:0]    e_gnt, e_vld;
      logic            e_dgnt, e_dvld;
      logic [N*SW-1:0] e_pk;
      logic [AW-1:0]   ga;
      int              src;
      @(negedge clk_in);
      e_vld = '0;
      e_dvld = 1'b0;
      ga = '0;
      if (ret_src.exists(cyc)) begin
         src = ret_src[cyc];
         if (src == N) begin
            e_dvld = 1'b1;
            m_dbg = ret_dat[cyc];
         end else begin
            e_vld[src] = 1'b1;
            m_osc[src] = ret_dat[cyc];
         end
         ret_src.delete(cyc);
         ret_dat.delete(cyc);
      end
      for (int k = 0; k < N; k++) e_pk[k*SW +: SW] = m_osc[k];
      checks++;
      if (osc_valid_out !== e_vld) begin
         errors++; $display("FAIL osc_valid cyc=%0d: got %b expected %b", cyc, osc_valid_out, e_vld);
      end
      checks++;
      if (dbg_valid_out !== e_dvld) begin
         errors++; $display("FAIL dbg_valid cyc=%0d: got %b expected %b", cyc, dbg_valid_out, e_dvld);
      end
      checks++;
      if (osc_data_out !== e_pk) begin
         errors++; $display("FAIL osc_data cyc=%0d: got %h expected %h", cyc, osc_data_out, e_pk);
      end
      checks++;
      if (dbg_data_out !== m_dbg) begin
         errors++; $display("FAIL dbg_data cyc=%0d: got %h expected %h", cyc, dbg_data_out, m_dbg);
      end
      checks++;
      if (mem_addr_out !== m_addr) begin
         errors++; $display("FAIL mem_addr cyc=%0d: got %h expected %h", cyc, mem_addr_out, m_addr);
      end
      e_gnt = '0;
      e_dgnt = 1'b0;
      src = -1;
      if (dbg_req_in && m_cnt == DMW) begin
         src = N;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (src < 0 && osc_req_in[(m_rr + i) % N]) src = (m_rr + i) % N;
         end
         if (src < 0 && dbg_req_in) src = N;
      end
      if (src >= 0 && src < N) begin
         e_gnt[src] = 1'b1;
         m_rr = (src + 1) % N;
         ga = osc_addr_in[src*AW +: AW];
      end else if (src == N) begin
         e_dgnt = 1'b1;
         ga = dbg_addr_in;
      end
      checks++;
      if (osc_gnt_out !== e_gnt) begin
         errors++; $display("FAIL osc_gnt cyc=%0d: got %b expected %b", cyc, osc_gnt_out, e_gnt);
      end
      checks++;
      if (dbg_gnt_out !== e_dgnt) begin
         errors++; $display("FAIL dbg_gnt cyc=%0d: got %b expected %b", cyc, dbg_gnt_out, e_dgnt);
      end
      if (src >= 0) begin
         ret_src[cyc + LAT + 2] = src;
         ret_dat[cyc + LAT + 2] = memf(ga);
         m_addr = ga;
      end
      if (dbg_req_in && !e_dgnt) m_cnt = (m_cnt < DMW) ? m_cnt + 1 : DMW;
      else m_cnt = 0;
      last_osc_gnt = osc_gnt_out;
      last_dbg_gnt = dbg_gnt_out;
      cyc++;
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      logic saw;
      do_reset();
      checks++;
      if (mem_addr_out !== '0 || osc_data_out !== '0 || dbg_data_out !== '0 ||
          osc_valid_out !== '0 || dbg_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got addr=%h odata=%h ddata=%h ovld=%b dvld=%b expected all zero",
                  mem_addr_out, osc_data_out, dbg_data_out, osc_valid_out, dbg_valid_out);
      end
      saw = 1'b0;
      repeat (20) begin
         cycle();
         if (osc_gnt_out != '0 || osc_valid_out != '0 || dbg_gnt_out || dbg_valid_out) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++; $display("FAIL idle_pulses: got pulse=%b expected 0", saw);
      end
   endtask

   task automatic test_single_osc();
      set_addr(2, 18'h00100);
      osc_req_in = 4'b0100;
      #1;
      checks++;
      if (osc_gnt_out !== 4'b0100) begin
         errors++; $display("FAIL single_gnt: got %b expected 0100", osc_gnt_out);
      end
      cycle();
      osc_req_in = '0;
      repeat (3) cycle();
      checks++;
      if (osc_valid_out !== 4'b0100 || osc_data_out[47:32] !== 16'hA4A5) begin
         errors++;
         $display("FAIL single_return: got vld=%b data=%h expected 0100 a4a5", osc_valid_out, osc_data_out[47:32]);
      end
      repeat (2) cycle();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] eg;
      logic [N-1:0] ev;
      logic [SW-1:0] ed;
      int r;
      do_reset();
      for (int k = 0; k < N; k++) set_addr(k, AW'((k + 1) * 16));
      osc_req_in = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         #1;
         eg = 4'b0001 << (i % 4);
         checks++;
         if (osc_gnt_out !== eg) begin
            errors++; $display("FAIL rr_order i=%0d: got %b expected %b", i, osc_gnt_out, eg);
         end
         if (i >= 4) begin
            r = (i - 4) % 4;
            ev = 4'b0001 << r;
            ed = 16'(((r + 1) * 16)) ^ 16'hA5A5;
            checks++;
            if (osc_valid_out !== ev || osc_data_out[r*SW +: SW] !== ed) begin
               errors++;
               $display("FAIL rr_return i=%0d: got vld=%b data=%h expected %b %h",
                        i, osc_valid_out, osc_data_out[r*SW +: SW], ev, ed);
            end
         end
         cycle();
      end
      osc_req_in = '0;
      repeat (6) cycle();
   endtask

   task automatic test_dbg_forced();
      int  n;
      logic got;
      do_reset();
      for (int k = 0; k < N; k++) set_addr(k, AW'(16'h1000 + k));
      osc_req_in = 4'b1111;
      dbg_addr_in = 18'h2ABCD;
      dbg_req_in = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         #1;
         n++;
         if (dbg_gnt_out) got = 1'b1;
         cycle();
      end
      checks++;
      if (!got || n != 17) begin
         errors++; $display("FAIL dbg_forced_slot: got granted=%b at cycle %0d expected 1 at 17", got, n);
      end
      dbg_req_in = 1'b0;
      #1;
      checks++;
      if (osc_gnt_out !== 4'b0001) begin
         errors++; $display("FAIL dbg_rr_resume: got %b expected 0001", osc_gnt_out);
      end
      repeat (4) cycle();
      osc_req_in = '0;
      repeat (6) cycle();
      checks++;
      if (dbg_data_out !== 16'h0E68) begin
         errors++; $display("FAIL dbg_data_value: got %h expected 0e68", dbg_data_out);
      end
   endtask

   task automatic test_reset_inflight();
      logic saw;
      do_reset();
      for (int k = 0; k < N; k++) set_addr(k, AW'(18'h3F000 + k * 3));
      osc_req_in = 4'b1111;
      repeat (6) cycle();
      osc_req_in = '0;
      #2;
      rst_n_in = 1'b0;
      #1;
      checks++;
      if (osc_valid_out !== '0 || dbg_valid_out !== 1'b0 || osc_data_out !== '0 ||
          dbg_data_out !== '0 || mem_addr_out !== '0 || osc_gnt_out !== '0 || dbg_gnt_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got vld=%b data=%h addr=%h gnt=%b expected zero",
                  osc_valid_out, osc_data_out, mem_addr_out, osc_gnt_out);
      end
      model_clear();
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         cycle();
         if (osc_valid_out != '0 || dbg_valid_out) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++; $display("FAIL stale_valid: got pulse=%b expected 0", saw);
      end
   endtask

   task automatic test_drop();
      logic saw;
      do_reset();
      for (int k = 0; k < N; k++) set_addr(k, AW'(18'h00200 + k));
      osc_req_in = 4'b1011;
      #1;
      checks++;
      if (osc_gnt_out !== 4'b0001) begin
         errors++; $display("FAIL drop_first: got %b expected 0001", osc_gnt_out);
      end
      cycle();
      osc_req_in = 4'b1000;
      #1;
      checks++;
      if (osc_gnt_out !== 4'b1000) begin
         errors++; $display("FAIL drop_skip: got %b expected 1000", osc_gnt_out);
      end
      cycle();
      osc_req_in = '0;
      saw = 1'b0;
      repeat (8) begin
         cycle();
         if (osc_valid_out[1]) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++; $display("FAIL drop_valid1: got %b expected 0", saw);
      end
   endtask

   task automatic test_random();
      osc_req_in = '0;
      dbg_req_in = 1'b0;
      last_osc_gnt = '0;
      last_dbg_gnt = 1'b0;
      repeat (400) begin
         for (int k = 0; k < N; k++) begin
            if (!osc_req_in[k]) begin
               if ($urandom_range(0, 99) < 35) begin
                  osc_req_in[k] = 1'b1;
                  set_addr(k, AW'($urandom));
               end
            end else if (last_osc_gnt[k]) begin
               if ($urandom_range(0, 99) < 50) set_addr(k, AW'($urandom));
               else osc_req_in[k] = 1'b0;
            end else if ($urandom_range(0, 99) < 5) begin
               osc_req_in[k] = 1'b0;
            end
         end
         if (!dbg_req_in) begin
            if ($urandom_range(0, 99) < 30) begin
               dbg_req_in = 1'b1;
               dbg_addr_in = AW'($urandom);
            end
         end else if (last_dbg_gnt) begin
            if ($urandom_range(0, 99) < 60) dbg_addr_in = AW'($urandom);
            else dbg_req_in = 1'b0;
         end
         cycle();
      end
      osc_req_in = '0;
      dbg_req_in = 1'b0;
      repeat (8) cycle();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_osc();
      test_round_robin();
      test_dbg_forced();
      test_reset_inflight();
      test_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
